// File: rtl/digit_fifo_ctrl.sv
// Controls a digit FIFO built around an external synchronous-write RAM.
// A registered output stage sits after the RAM. The RAM read address is steered
// so that ram_q always presents the current head of the buffered digits.
module digit_fifo_ctrl #(
    parameter int unsigned DATA_WIDTH = 2,
    parameter int unsigned ADDR_WIDTH = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_digit,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_digit,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH+1:0] count,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic [ADDR_WIDTH-1:0] ram_write_addr,
    output logic [ADDR_WIDTH-1:0] ram_read_addr,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_q
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned RC_W  = ADDR_WIDTH + 1;
    localparam int unsigned CNT_W = ADDR_WIDTH + 2;

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [RC_W-1:0]       ram_count_q, ram_count_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_digit_q, out_digit_d;
    logic                  push;
    logic                  load;

    // Handshake decode from current state; a held reset suppresses writes.
    always_comb begin
        in_ready = (ram_count_q != RC_W'(DEPTH)) && !clear;
        push     = in_valid && in_ready && rst_n;
        load     = (ram_count_q != '0) && (!out_valid_q || out_ready) && !clear;
    end

    // RAM port drive; read address looks one ahead when the head is consumed.
    always_comb begin
        ram_we         = push;
        ram_write_addr = wr_ptr_q;
        ram_data       = in_digit;
        ram_read_addr  = load ? (rd_ptr_q + ADDR_WIDTH'(1)) : rd_ptr_q;
    end

    // Next-state computation for pointers, occupancy and the output stage.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        ram_count_d = ram_count_q;
        out_valid_d = out_valid_q;
        out_digit_d = out_digit_q;
        if (clear) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            ram_count_d = '0;
            out_valid_d = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
            end
            if (load) begin
                rd_ptr_d    = rd_ptr_q + ADDR_WIDTH'(1);
                out_digit_d = ram_q;
                out_valid_d = 1'b1;
            end else if (out_ready) begin
                out_valid_d = 1'b0;
            end
            ram_count_d = ram_count_q + RC_W'(push) - RC_W'(load);
        end
    end

    // State registers; RAM contents are deliberately never reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            ram_count_q <= '0;
            out_valid_q <= 1'b0;
            out_digit_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            ram_count_q <= ram_count_d;
            out_valid_q <= out_valid_d;
            out_digit_q <= out_digit_d;
        end
    end

    // Occupancy includes the digit parked in the output register.
    always_comb begin
        out_valid = out_valid_q;
        out_digit = out_digit_q;
        count     = CNT_W'(ram_count_q) + CNT_W'(out_valid_q);
    end

endmodule

// File: tb/tb_digit_fifo_ctrl.sv
// Randomized scoreboard bench for digit_fifo_ctrl with a behavioural RAM.
module tb_digit_fifo_ctrl;

    localparam int DW    = 2;
    localparam int AW    = 7;
    localparam int DEPTH = 128;

    logic          clk;
    logic          rst_n;
    logic          clear;
    logic          in_valid;
    logic [DW-1:0] in_digit;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_digit;
    logic          out_ready;
    logic [AW+1:0] count;
    logic [DW-1:0] ram_data;
    logic [AW-1:0] ram_write_addr;
    logic [AW-1:0] ram_read_addr;
    logic          ram_we;
    logic [DW-1:0] ram_q;

    // Digit RAM: write on we, read address registered, data combinational.
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] raddr_q;
    always @(posedge clk) begin
        if (ram_we) mem[ram_write_addr] <= ram_data;
        raddr_q <= ram_read_addr;
    end
    assign ram_q = mem[raddr_q];

    digit_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .clear          (clear),
        .in_valid       (in_valid),
        .in_digit       (in_digit),
        .in_ready       (in_ready),
        .out_valid      (out_valid),
        .out_digit      (out_digit),
        .out_ready      (out_ready),
        .count          (count),
        .ram_data       (ram_data),
        .ram_write_addr (ram_write_addr),
        .ram_read_addr  (ram_read_addr),
        .ram_we         (ram_we),
        .ram_q          (ram_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            total = 0;
    int            bad   = 0;
    logic [DW-1:0] sb [$];
    int            ram_n = 0;
    int            ov_m  = 0;
    int            push_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; checks DUT state against the model, then advances the model.
    task automatic step(input logic iv, input logic [DW-1:0] d, input logic ordy, input logic clr);
        logic exp_rdy;
        logic pu;
        logic ld;
        @(negedge clk);
        in_valid  = iv;
        in_digit  = d;
        out_ready = ordy;
        clear     = clr;
        #1;
        exp_rdy = (ram_n != DEPTH) && !clr;
        pu      = iv && exp_rdy;
        chk("in_ready", int'(in_ready), int'(exp_rdy));
        chk("out_valid", int'(out_valid), ov_m);
        chk("count", int'(count), ram_n + ov_m);
        chk("ram_we", int'(ram_we), int'(pu));
        if (clr) begin
            sb.delete();
            ram_n = 0;
            ov_m  = 0;
        end else begin
            ld = (ram_n != 0) && (ov_m == 0 || ordy);
            if (pu) begin
                sb.push_back(d);
                push_cnt++;
            end
            ram_n = ram_n + int'(pu) - int'(ld);
            if (ld) ov_m = 1;
            else if (ordy) ov_m = 0;
        end
    endtask

    task automatic drain(input int maxc);
        int c;
        c = 0;
        while ((ram_n + ov_m) != 0 && c < maxc) begin
            step(1'b0, '0, 1'b1, 1'b0);
            c++;
        end
        step(1'b0, '0, 1'b1, 1'b0);
        chk("drain_count", int'(count), 0);
    endtask

    task automatic seq_three();
        step(1'b1, 2'b01, 1'b1, 1'b0);
        step(1'b1, 2'b11, 1'b1, 1'b0);
        step(1'b1, 2'b00, 1'b1, 1'b0);
        chk("latency_valid", int'(out_valid), 1);
        chk("latency_digit", int'(out_digit), 1);
        drain(10);
    endtask

    // Monitor: every output handshake pops the oldest accepted digit.
    initial begin
        logic [DW-1:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && !clear && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("out_digit", int'(out_digit), int'(e));
                end
            end
        end
    end

    initial begin
        logic iv;
        logic ordy;
        int   guard;
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
        raddr_q   = AW'($urandom);
        rst_n     = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b1;
        in_digit  = 2'b11;
        out_ready = 1'b1;
        #2;
        chk("rst_count", int'(count), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_digit", int'(out_digit), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_ram_we", int'(ram_we), 0);
        @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;

        // Short stream with downstream always ready.
        seq_three();

        // Fill RAM plus output register, then try one more digit.
        for (int i = 0; i < 129; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0);
        step(1'b1, DW'($urandom), 1'b0, 1'b0);
        chk("full_count", int'(count), 129);
        chk("full_in_ready", int'(in_ready), 0);
        drain(200);

        // Random traffic across pointer wrap.
        push_cnt = 0;
        guard    = 0;
        while (push_cnt < 300 && guard < 5000) begin
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) != 0);
            step(iv, DW'($urandom), ordy, 1'b0);
            chk("count_max", int'(count <= 129), 1);
            guard++;
        end
        chk("random_pushes", push_cnt, 300);
        drain(200);

        // One digit in RAM, push and load together every cycle.
        step(1'b1, DW'($urandom), 1'b0, 1'b0);
        step(1'b1, DW'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, DW'($urandom), 1'b1, 1'b0);
            chk("stream_count", int'(count), 2);
            chk("stream_valid", int'(out_valid), 1);
        end
        drain(20);

        // Clear with 50 digits held.
        for (int i = 0; i < 50; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        chk("pre_clear_count", int'(count), 50);
        step(1'b1, DW'($urandom), 1'b1, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("clear_count", int'(count), 0);
        chk("clear_valid", int'(out_valid), 0);
        for (int i = 0; i < 10; i++) step(1'b1, DW'($urandom), 1'b1, 1'b0);
        drain(30);

        // Asynchronous reset mid-cycle with 20 digits held.
        for (int i = 0; i < 20; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #3;
        chk("pre_rst_count", int'(count), 20);
        rst_n = 1'b0;
        #1;
        chk("async_rst_count", int'(count), 0);
        chk("async_rst_valid", int'(out_valid), 0);
        sb.delete();
        ram_n = 0;
        ov_m  = 0;
        @(negedge clk);
        rst_n = 1'b1;
        seq_three();

        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
